regfile_wb_arbiter: RTL

- Owns the four-entry saved-register bank (addresses 5'b10000–5'b10011, $s0–$s3).
- Drives the bank contents continuously onto the v0..v3 inputs of the combinational register-file read block.
- Arbitrates the bank's single write port between two writeback requesters, ALU writeback (port 0) and memory-load writeback (port 1), using round-robin with valid/ready handshakes.
- Counts rejected writes to addresses outside the bank.

---
 rtl/regfile_wb_arbiter_if.sv | 30 +++
 rtl/regfile_wb_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: ALU (port 0) and memory-load (port 1) valid/ready channels.
interface regfile_wb_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  // Requester side
  modport master (
    output alu_valid, alu_addr, alu_data,
    input  alu_ready,
    output mem_valid, mem_addr, mem_data,
    input  mem_ready
  );

  // Arbiter side
  modport slave (
    input  alu_valid, alu_addr, alu_data,
    output alu_ready,
    input  mem_valid, mem_addr, mem_data,
    output mem_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Saved-register bank ($s0-$s3) with a round-robin arbitrated write port
// and a saturating counter of out-of-range writeback attempts.
module regfile_wb_arbiter #(
  parameter int unsigned        DATA_W    = 32,
  parameter int unsigned        ADDR_W    = 5,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = ADDR_W'(16),
  parameter int unsigned        ERR_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_hold,
  regfile_wb_arbiter_if.slave   wb,
  output logic [DATA_W-1:0]     v0,
  output logic [DATA_W-1:0]     v1,
  output logic [DATA_W-1:0]     v2,
  output logic [DATA_W-1:0]     v3,
  output logic                  oor_pulse,
  output logic [ERR_CNT_W-1:0]  oor_count
);

  localparam int unsigned BANK_N = 4;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  grant_e               r_last_grant;
  grant_e               w_next_grant;
  logic                 w_alu_ready;
  logic                 w_mem_ready;
  logic                 w_alu_xfer;
  logic                 w_mem_xfer;
  logic                 w_wr_en;
  logic                 w_in_range;
  logic [ADDR_W-1:0]    w_wr_addr;
  logic [ADDR_W-1:0]    w_offset;
  logic [DATA_W-1:0]    w_wr_data;
  logic [DATA_W-1:0]    r_bank [BANK_N];
  logic                 r_oor_pulse;
  logic [ERR_CNT_W-1:0] r_oor_count;

  // Round-robin pointer: remembers the last requester that completed a transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= GRANT_MEM;
    end else begin
      r_last_grant <= w_next_grant;
    end
  end

  // Grant decode and pointer next-state; ready depends only on valids, hold and pointer
  always_comb begin
    w_alu_ready  = 1'b0;
    w_mem_ready  = 1'b0;
    w_next_grant = r_last_grant;
    if (!wb_hold) begin
      if (wb.alu_valid && wb.mem_valid) begin
        if (r_last_grant == GRANT_MEM) begin
          w_alu_ready = 1'b1;
        end else begin
          w_mem_ready = 1'b1;
        end
      end else if (wb.alu_valid) begin
        w_alu_ready = 1'b1;
      end else if (wb.mem_valid) begin
        w_mem_ready = 1'b1;
      end
    end
    w_alu_xfer = wb.alu_valid && w_alu_ready;
    w_mem_xfer = wb.mem_valid && w_mem_ready;
    if (w_alu_xfer) begin
      w_next_grant = GRANT_ALU;
    end else if (w_mem_xfer) begin
      w_next_grant = GRANT_MEM;
    end
  end

  // Winning request's address/data and bank range check
  always_comb begin
    w_wr_en    = w_alu_xfer || w_mem_xfer;
    w_wr_addr  = w_alu_xfer ? wb.alu_addr : wb.mem_addr;
    w_wr_data  = w_alu_xfer ? wb.alu_data : wb.mem_data;
    w_offset   = w_wr_addr - BASE_ADDR;
    w_in_range = (w_offset < ADDR_W'(BANK_N));
  end

  // Bank registers: only the addressed entry loads on an in-range transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(BANK_N); i++) begin
        r_bank[i] <= '0;
      end
    end else if (w_wr_en && w_in_range) begin
      r_bank[w_offset[1:0]] <= w_wr_data;
    end
  end

  // Out-of-range flag for the following cycle and saturating error count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oor_pulse <= 1'b0;
      r_oor_count <= '0;
    end else begin
      r_oor_pulse <= w_wr_en && !w_in_range;
      if (w_wr_en && !w_in_range && (r_oor_count != '1)) begin
        r_oor_count <= r_oor_count + ERR_CNT_W'(1);
      end
    end
  end

  assign wb.alu_ready = w_alu_ready;
  assign wb.mem_ready = w_mem_ready;
  assign v0           = r_bank[0];
  assign v1           = r_bank[1];
  assign v2           = r_bank[2];
  assign v3           = r_bank[3];
  assign oor_pulse    = r_oor_pulse;
  assign oor_count    = r_oor_count;

endmodule
